// File: rtl/ah_wb_drain_ctrl.sv
// Write-buffer drain controller: pops buffered writes to memory and serves snooped reads.
// Optional mem_ack wait timeout is compiled in when AH_DRAIN_TIMEOUT_EN is defined.
module ah_wb_drain_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_BURST = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADDR_W+DATA_W-1:0] fifo_rdata,
  input  logic                     fifo_rvalid,
  output logic                     fifo_rready,
  output logic [ADDR_W-1:0]        snp_data,
  output logic                     snp_valid,
  input  logic                     snp_match,
  input  logic [ADDR_W-1:0]        rd_req_addr,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  output logic [DATA_W-1:0]        rd_rsp_data,
  output logic                     rd_rsp_valid,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic                     err
);

  localparam int BW = $clog2(RD_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(RD_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1'b1);
  localparam logic [BW-1:0] BURST_ZERO = BW'(1'b0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
  logic [ADDR_W+DATA_W-1:0]   wr_q, wr_d;
  logic [BW-1:0]              burst_q, burst_d;
  logic                       pend_q, pend_d;
  logic [DATA_W-1:0]          rsp_data_q, rsp_data_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       err_q, err_d;
  logic                       alive_q;
  logic                       expired_s;

  // Next-state and Moore/Mealy output decode; IDLE is held off until the first clock after reset.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_d        = wr_q;
    burst_d     = burst_q;
    pend_d      = pend_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    err_d       = err_q;
    fifo_rready = 1'b0;
    rd_req_ready = 1'b0;
    snp_valid   = 1'b0;
    snp_data    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (!alive_q) begin
          state_d = IDLE;
        end else if (rd_req_valid && ((burst_q < BURST_MAX) || !fifo_rvalid)) begin
          rd_req_ready = 1'b1;
          rd_addr_d    = rd_req_addr;
          if (!fifo_rvalid) begin
            burst_d = BURST_ZERO;
          end else if (burst_q == BURST_MAX) begin
            burst_d = burst_q;
          end else begin
            burst_d = burst_q + BURST_ONE;
          end
          state_d = CHECK;
        end else if (fifo_rvalid) begin
          fifo_rready = 1'b1;
          wr_d        = fifo_rdata;
          burst_d     = BURST_ZERO;
          state_d     = WRITE;
        end else begin
          rd_req_ready = 1'b1;
          burst_d      = BURST_ZERO;
        end
      end
      CHECK: begin
        snp_valid = 1'b1;
        snp_data  = rd_addr_q;
        // A hit with an empty FIFO is a stale snoop result, not a hazard.
        if (snp_match && fifo_rvalid) begin
          state_d = DRAIN;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        fifo_rready = 1'b1;
        wr_d        = fifo_rdata;
        pend_d      = 1'b1;
        burst_d     = BURST_ZERO;
        state_d     = WRITE;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_q[ADDR_W-1:0];
        mem_wdata = wr_q[ADDR_W +: DATA_W];
        if (mem_ack) begin
          state_d = pend_q ? CHECK : IDLE;
        end else if (expired_s) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr_q;
        if (mem_ack) begin
          rsp_data_d  = mem_rdata;
          rsp_valid_d = 1'b1;
          pend_d      = 1'b0;
          state_d     = IDLE;
        end else if (expired_s) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef AH_DRAIN_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_q, wait_d;

  // Wait counter restarts on every state change and advances while a request is outstanding.
  always_comb begin
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (mem_req) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  assign expired_s = (wait_q == TO_LAST);

  // Wait counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT);
  assign expired_s      = 1'b0;
`endif

  // Controller state and registered response/error outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      wr_q        <= '0;
      burst_q     <= BURST_ZERO;
      pend_q      <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wr_q        <= wr_d;
      burst_q     <= burst_d;
      pend_q      <= pend_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      alive_q     <= 1'b1;
    end
  end

  assign rd_rsp_data  = rsp_data_q;
  assign rd_rsp_valid = rsp_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ah_wb_drain_ctrl.sv
// Self-checking bench for ah_wb_drain_ctrl: FIFO/memory models, scoreboard and vector table.
module tb_ah_wb_drain_ctrl;
`ifdef AH_DRAIN_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] fifo_rdata = 32'h0;
  logic        fifo_rvalid = 1'b0;
  logic        fifo_rready;
  logic [15:0] snp_data;
  logic        snp_valid;
  logic        snp_match = 1'b0;
  logic [15:0] rd_req_addr = 16'h0;
  logic        rd_req_valid = 1'b0;
  logic        rd_req_ready;
  logic [15:0] rd_rsp_data;
  logic        rd_rsp_valid;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
  logic        err;

  ah_wb_drain_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_BURST(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .fifo_rdata(fifo_rdata), .fifo_rvalid(fifo_rvalid),
    .fifo_rready(fifo_rready), .snp_data(snp_data), .snp_valid(snp_valid),
    .snp_match(snp_match), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] fifo_q[$];
  logic [15:0] rd_src_q[$];
  logic [15:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];
  logic [16:0] memop_log[$];
  bit          ev_log[$];
  logic [15:0] tbmem[logic [15:0]];
  logic [15:0] golden[logic [15:0]];
  int ack_wait = 0;
  bit ack_force = 1'b0;
  bit ack_block = 1'b0;
  int age = 0;
  bit done_flag = 1'b0;

  function automatic logic [15:0] mem_lookup(input logic [15:0] a);
    return tbmem.exists(a) ? tbmem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] gold_lookup(input logic [15:0] a);
    return golden.exists(a) ? golden[a] : 16'h0000;
  endfunction

  // Environment: bookkeeping on the falling edge, input drive just after the rising edge.
  always begin
    @(negedge clk);
    done_flag = 1'b0;
    if (rd_rsp_valid) begin
      if (exp_rd_q.size() == 0) chk("rsp_unexpected", {63'd0, rd_rsp_valid}, 64'd0);
      else chk("sb_rsp_data", {48'd0, rd_rsp_data}, {48'd0, exp_rd_q.pop_front()});
    end
    if (rd_req_valid && rd_req_ready) begin
      void'(rd_src_q.pop_front());
      exp_rd_q.push_back(gold_lookup(rd_req_addr));
      ev_log.push_back(1'b0);
    end
    if (fifo_rready && fifo_rvalid) begin
      void'(fifo_q.pop_front());
      ev_log.push_back(1'b1);
    end
    if (mem_req && mem_ack) begin
      done_flag = 1'b1;
      memop_log.push_back({mem_we, mem_addr});
      if (mem_we) begin
        tbmem[mem_addr] = mem_wdata;
        if (exp_wr_q.size() == 0) chk("wr_unexpected", {63'd0, mem_we}, 64'd0);
        else chk("sb_wr_op", {32'd0, mem_wdata, mem_addr}, {32'd0, exp_wr_q.pop_front()});
      end
    end
    @(posedge clk);
    #2;
    fifo_rvalid  = (fifo_q.size() > 0);
    fifo_rdata   = fifo_rvalid ? fifo_q[0] : 32'h0;
    rd_req_valid = (rd_src_q.size() > 0);
    rd_req_addr  = rd_req_valid ? rd_src_q[0] : 16'h0;
    snp_match    = 1'b0;
    if (snp_valid) begin
      foreach (fifo_q[i]) if (fifo_q[i][15:0] == snp_data) snp_match = 1'b1;
    end
    if (done_flag || !mem_req) age = 0;
    mem_ack   = ack_force || (mem_req && !ack_block && (age >= ack_wait));
    if (mem_req) age++;
    mem_rdata = mem_lookup(mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    fifo_q.push_back({d, a});
    exp_wr_q.push_back({d, a});
    golden[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {57'd0, fifo_rready, snp_valid, rd_req_ready, rd_rsp_valid, mem_req, mem_we, err}, 64'd0);
    chk({tag, "_data"}, {snp_data, rd_rsp_data, mem_addr, mem_wdata}, 64'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && rd_src_q.size() == 0 && rd_req_ready && !rd_rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, {63'd0, ok}, 64'd1);
  endtask

  typedef struct {
    bit          is_rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          wt;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vt[10];

  initial begin
    bit found;
    int lat;
    int nreq;
    logic [16:0] hz_exp[3];

    vt[0] = '{1'b0, 16'h0010, 16'hBEEF, 0, 16'h0000, 2};
    vt[1] = '{1'b1, 16'h0020, 16'h0000, 0, 16'h1234, 3};
    vt[2] = '{1'b1, 16'h0010, 16'h0000, 0, 16'hBEEF, 3};
    vt[3] = '{1'b0, 16'h0050, 16'hA5A5, 2, 16'h0000, 4};
    vt[4] = '{1'b1, 16'h0050, 16'h0000, 3, 16'hA5A5, 6};
    vt[5] = '{1'b1, 16'h0777, 16'h0000, 1, 16'h0000, 4};
    vt[6] = '{1'b0, 16'hFFFF, 16'h0001, 0, 16'h0000, 2};
    vt[7] = '{1'b1, 16'hFFFF, 16'h0000, 0, 16'h0001, 3};
    vt[8] = '{1'b0, 16'h0000, 16'hFFFF, 1, 16'h0000, 3};
    vt[9] = '{1'b1, 16'h0000, 16'h0000, 0, 16'hFFFF, 3};
    hz_exp[0] = 17'h10030;
    hz_exp[1] = 17'h10040;
    hz_exp[2] = 17'h00040;
    tbmem[16'h0020]  = 16'h1234;
    golden[16'h0020] = 16'h1234;

    #3;
    check_all_zero("rst");
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    #1 chk("rdy_in_release_cycle", {63'd0, rd_req_ready}, 64'd0);
    @(negedge clk);
    chk("rdy_after_release", {63'd0, rd_req_ready}, 64'd1);

    for (int i = 0; i < 10; i++) begin
      ack_wait = vt[i].wt;
      tick();
      if (vt[i].is_rd) rd_src_q.push_back(vt[i].addr);
      else push_wr(vt[i].addr, vt[i].wdata);
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (vt[i].is_rd ? (rd_req_valid && rd_req_ready) : fifo_rready) begin
          found = 1'b1;
          break;
        end
      end
      chk($sformatf("v%0d_start", i), {63'd0, found}, 64'd1);
      lat = 0;
      for (int c = 1; c < 40; c++) begin
        @(negedge clk);
        if (c == 1) begin
          if (vt[i].is_rd) chk($sformatf("v%0d_snoop", i), {47'd0, snp_valid, snp_data}, {47'd0, 1'b1, vt[i].addr});
          else chk($sformatf("v%0d_wreq", i), {29'd0, fifo_rready, mem_req, mem_we, mem_addr, mem_wdata},
                   {29'd0, 1'b0, 1'b1, 1'b1, vt[i].addr, vt[i].wdata});
        end
        if (vt[i].is_rd ? rd_rsp_valid : rd_req_ready) begin
          lat = c;
          break;
        end
      end
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].exp_lat));
      if (vt[i].is_rd) chk($sformatf("v%0d_rdata", i), {48'd0, rd_rsp_data}, {48'd0, vt[i].exp_data});
      wait_idle($sformatf("v%0d", i), 50);
    end

    tick();
    ack_wait  = 0;
    ack_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ack_in_idle", {60'd0, mem_req, rd_req_ready, rd_rsp_valid, fifo_rready}, 64'h4);
    end
    tick();
    ack_force = 1'b0;

    tick();
    memop_log.delete();
    push_wr(16'h0030, 16'h3333);
    push_wr(16'h0040, 16'h4444);
    rd_src_q.push_back(16'h0040);
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rd_rsp_valid) begin
        found = 1'b1;
        chk("hz_data", {48'd0, rd_rsp_data}, 64'h4444);
        break;
      end
    end
    chk("hz_rsp", {63'd0, found}, 64'd1);
    chk("hz_nops", 64'(memop_log.size()), 64'd3);
    if (memop_log.size() == 3) begin
      for (int k = 0; k < 3; k++) chk($sformatf("hz_op%0d", k), {47'd0, memop_log[k]}, {47'd0, hz_exp[k]});
    end
    wait_idle("hz", 50);

    tick();
    ev_log.delete();
    for (int k = 0; k < 5; k++) push_wr(16'h0200 + 16'(k), 16'h2000 + 16'(k));
    for (int k = 0; k < 12; k++) rd_src_q.push_back(16'h0100 + 16'(k));
    wait_idle("fair", 300);
    chk("fair_nev", 64'(ev_log.size()), 64'd17);
    for (int k = 0; k < ev_log.size() && k < 17; k++) begin
      chk($sformatf("fair_ev%0d", k), {63'd0, ev_log[k]}, {63'd0, ((k % 5) == 4) || (k >= 15)});
    end

`ifdef AH_DRAIN_TIMEOUT_EN
    tick();
    ack_block = 1'b1;
    rd_src_q.push_back(16'h0020);
    nreq = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (err) break;
    end
    chk("to_err", {63'd0, err}, 64'd1);
    chk("to_reqcyc", 64'(nreq), 64'd10);
    repeat (5) begin
      @(negedge clk);
      chk("to_sticky", {60'd0, err, rd_rsp_valid, mem_req, rd_req_ready}, 64'h9);
    end
    chk("to_no_rsp", 64'(exp_rd_q.size()), 64'd1);
    tick();
    exp_rd_q.delete();
    ack_block = 1'b0;
`else
    nreq = 0;
`endif

    chk("sb_rd_drained", 64'(exp_rd_q.size()), 64'd0);
    chk("sb_wr_drained", 64'(exp_wr_q.size()), 64'd0);

    tick();
    ack_wait = 50;
    push_wr(16'h0060, 16'h6666);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) begin
        found = 1'b1;
        break;
      end
    end
    chk("rw_req_seen", {63'd0, found}, 64'd1);
    #1 rstn = 1'b0;
    #1 check_all_zero("rw");
    exp_wr_q.delete();
    ack_wait = 0;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    #1 chk("rw_rdy_release", {63'd0, rd_req_ready}, 64'd0);
    @(negedge clk);
    chk("rw_post", {61'd0, rd_req_ready, mem_req, fifo_rready}, 64'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
